// File: rtl/data_unshifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_shift_pkg
// Description : Shared FSM state encoding and shift-direction constants for
//               the data_unshifter block.
// Revision    : 1.0 - initial release
// ============================================================================
package data_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

endpackage : data_shift_pkg
`default_nettype wire

// File: rtl/data_unshifter_if.sv
`default_nettype none
// ============================================================================
// Module      : data_unshifter_if
// Description : Producer/consumer valid-ready bundle of the data_unshifter.
//               in_arith exists only when DATA_UNSHIFTER_ARITH_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_unshifter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int AMT_WIDTH  = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [AMT_WIDTH-1:0]  in_amt;
    logic                  in_dir;
    logic                  in_rot;
`ifdef DATA_UNSHIFTER_ARITH_EN
    logic                  in_arith;
`endif
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport slave (
`ifdef DATA_UNSHIFTER_ARITH_EN
        input  in_arith,
`endif
        input  in_valid, in_data, in_amt, in_dir, in_rot, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
`ifdef DATA_UNSHIFTER_ARITH_EN
        output in_arith,
`endif
        output in_valid, in_data, in_amt, in_dir, in_rot, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface : data_unshifter_if
`default_nettype wire

// File: rtl/data_unshifter_step.sv
`default_nettype none
// ============================================================================
// Module      : data_shift_step
// Description : Combinational fixed-amount shift/rotate of one word.
// Revision    : 1.0 - initial release
// ============================================================================
module data_shift_step
    import data_shift_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int AMOUNT     = 1
) (
    input  wire logic [DATA_WIDTH-1:0] data_in,
    input  wire logic                  dir,
    input  wire logic                  rot,
    input  wire logic                  fill_bit,
    output logic      [DATA_WIDTH-1:0] data_out
);

    always_comb begin
        data_out = data_in;
        if (dir == DIR_LEFT) begin
            // Left shifts never sign-fill; fill_bit only matters going right.
            data_out = rot ? {data_in[DATA_WIDTH-AMOUNT-1:0], data_in[DATA_WIDTH-1:DATA_WIDTH-AMOUNT]}
                           : {data_in[DATA_WIDTH-AMOUNT-1:0], {AMOUNT{1'b0}}};
        end else begin
            data_out = rot ? {data_in[AMOUNT-1:0], data_in[DATA_WIDTH-1:AMOUNT]}
                           : {{AMOUNT{fill_bit}}, data_in[DATA_WIDTH-1:AMOUNT]};
        end
    end

endmodule : data_shift_step
`default_nettype wire

// File: rtl/data_unshifter.sv
`default_nettype none
// ============================================================================
// Module      : data_unshifter
// Description : Iterative handshaked shift/rotate engine, coarse steps first
//               then single-bit steps. Optional macro DATA_UNSHIFTER_ARITH_EN
//               adds sign-filling right shifts.
// Revision    : 1.0 - initial release
// ============================================================================
module data_unshifter
    import data_shift_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int STEP_WIDTH = 4,
    parameter int AMT_WIDTH  = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    data_unshifter_if.slave   bus,
    output logic              busy
);

    localparam logic [31:0]          c_step_wide = STEP_WIDTH;
    localparam logic [AMT_WIDTH-1:0] c_step_amt  = AMT_WIDTH'(STEP_WIDTH);
    localparam logic [AMT_WIDTH-1:0] c_one_amt   = AMT_WIDTH'(1);

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_out;
    logic [AMT_WIDTH-1:0]  r_rem;
    logic                  r_dir;
    logic                  r_rot;
    logic [DATA_WIDTH-1:0] w_coarse;
    logic [DATA_WIDTH-1:0] w_fine;
    logic [DATA_WIDTH-1:0] w_stepped;
    logic [AMT_WIDTH-1:0]  w_rem_next;
    logic                  w_use_coarse;
    logic                  w_last;
    logic                  w_accept;
    logic                  w_fill;

`ifdef DATA_UNSHIFTER_ARITH_EN
    logic r_arith;
    assign w_fill = r_arith & r_data[DATA_WIDTH-1];
`else
    assign w_fill = 1'b0;
`endif

    assign w_use_coarse = 32'(r_rem) >= c_step_wide;
    assign w_rem_next   = r_rem - (w_use_coarse ? c_step_amt : c_one_amt);
    assign w_last       = (w_rem_next == '0);
    assign w_stepped    = w_use_coarse ? w_coarse : w_fine;
    assign w_accept     = (r_state == IDLE) && bus.in_valid;
    assign bus.out_data = r_out;

    data_shift_step #(.DATA_WIDTH(DATA_WIDTH), .AMOUNT(STEP_WIDTH)) u_step_coarse (
        .data_in  (r_data),
        .dir      (r_dir),
        .rot      (r_rot),
        .fill_bit (w_fill),
        .data_out (w_coarse)
    );

    data_shift_step #(.DATA_WIDTH(DATA_WIDTH), .AMOUNT(1)) u_step_fine (
        .data_in  (r_data),
        .dir      (r_dir),
        .rot      (r_rot),
        .fill_bit (w_fill),
        .data_out (w_fine)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_next_state = (bus.in_amt == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_last) w_next_state = DONE;
            end
            DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // r_out is only touched when a result completes, so it holds through IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_out   <= '0;
            r_rem   <= '0;
            r_dir   <= 1'b0;
            r_rot   <= 1'b0;
`ifdef DATA_UNSHIFTER_ARITH_EN
            r_arith <= 1'b0;
`endif
        end else if (w_accept) begin
            r_data  <= bus.in_data;
            r_rem   <= bus.in_amt;
            r_dir   <= bus.in_dir;
            r_rot   <= bus.in_rot;
`ifdef DATA_UNSHIFTER_ARITH_EN
            r_arith <= bus.in_arith;
`endif
            if (bus.in_amt == '0) r_out <= bus.in_data;
        end else if (r_state == SHIFT) begin
            r_data <= w_stepped;
            r_rem  <= w_rem_next;
            if (w_last) r_out <= w_stepped;
        end
    end

endmodule : data_unshifter
`default_nettype wire

// File: tb/tb_data_unshifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_unshifter
// Description : Scoreboard bench for data_unshifter: directed vectors, stall,
//               mid-operation reset and back-to-back random words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_unshifter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] q_exp[$];

    data_unshifter_if #(.DATA_WIDTH(16), .AMT_WIDTH(4)) bus ();

    data_unshifter #(.DATA_WIDTH(16), .STEP_WIDTH(4), .AMT_WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] d, input int amt,
                                          input logic dir, input logic rot, input logic ar);
        logic [15:0] v;
        logic        fb;
        v = d;
        for (int i = 0; i < amt; i++) begin
            if (dir) begin
                fb = rot ? v[15] : 1'b0;
                v  = {v[14:0], fb};
            end else begin
`ifdef DATA_UNSHIFTER_ARITH_EN
                fb = rot ? v[0] : (ar & v[15]);
`else
                fb = rot ? v[0] : 1'b0;
`endif
                v  = {fb, v[15:1]};
            end
        end
        return v;
    endfunction

    task automatic drive(input logic [15:0] d, input logic [3:0] a,
                         input logic dir, input logic rot, input logic ar);
        bus.in_data = d;
        bus.in_amt  = a;
        bus.in_dir  = dir;
        bus.in_rot  = rot;
`ifdef DATA_UNSHIFTER_ARITH_EN
        bus.in_arith = ar;
`else
        if (ar) bus.in_rot = rot;
`endif
    endtask

    // Issue one word at IDLE, push its expected result, then measure latency.
    task automatic send(input string name, input logic [15:0] d, input logic [3:0] a,
                        input logic dir, input logic rot, input logic ar,
                        input logic [15:0] exp, input int exp_lat);
        int g;
        int lat;
        g = 0;
        @(negedge clk);
        while (!bus.in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        drive(d, a, dir, rot, ar);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        q_exp.push_back(exp);
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
    endtask

    // Monitor: compare every completed output handshake against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (q_exp.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_out: got %0h expected no output", bus.out_data);
                end else begin
                    check("out_data", {16'h0, bus.out_data}, {16'h0, q_exp.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic [3:0]  ra;
        logic        rdir, rrot, rar;
        int          g;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(16'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data",  bus.out_data,  0);
        check("rst_busy",      busy,          0);
        @(posedge clk);
        #1 rst = 1'b0;

        send("rotl4",  16'h1234, 4'd4,  1'b1, 1'b1, 1'b0, 16'h2341, 1);
        send("rotr6",  16'h1234, 4'd6,  1'b0, 1'b1, 1'b0, 16'hD048, 3);
        send("shl15",  16'h8001, 4'd15, 1'b1, 1'b0, 1'b0, 16'h8000, 6);
`ifdef DATA_UNSHIFTER_ARITH_EN
        send("sra4",   16'h8000, 4'd4,  1'b0, 1'b0, 1'b1, 16'hF800, 1);
`else
        send("sra4",   16'h8000, 4'd4,  1'b0, 1'b0, 1'b1, 16'h0800, 1);
`endif
        send("shr4",   16'h8000, 4'd4,  1'b0, 1'b0, 1'b0, 16'h0800, 1);

        // Stall: result must hold while the consumer is not ready.
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        send("amt0", 16'hBEEF, 4'd0, 1'b1, 1'b0, 1'b0, 16'hBEEF, 0);
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_out_data",  bus.out_data,  16'hBEEF);
            check("stall_in_ready",  bus.in_ready,  0);
            check("stall_busy",      busy,          1);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;

        // Reset while a long shift is in flight: the word is dropped.
        g = 0;
        @(negedge clk);
        while (!bus.in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        drive(16'hA5A5, 4'd15, 1'b1, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_data",  bus.out_data,  0);
        check("midrst_busy",      busy,          0);
        check("midrst_in_ready",  bus.in_ready,  1);
        @(posedge clk);
        #1 rst = 1'b0;
        send("post_rst_rotl4", 16'h1234, 4'd4, 1'b1, 1'b1, 1'b0, 16'h2341, 1);

        // Back-to-back: in_valid stays high; each word must be taken exactly once.
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            rd   = 16'($urandom);
            ra   = 4'($urandom_range(0, 15));
            rdir = 1'($urandom_range(0, 1));
            rrot = 1'($urandom_range(0, 1));
            rar  = 1'($urandom_range(0, 1));
            drive(rd, ra, rdir, rrot, rar);
            bus.in_valid = 1'b1;
            g = 0;
            @(negedge clk);
            while (!bus.in_ready && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (!bus.in_ready) check("b2b_accept_timeout", 0, 1);
            @(posedge clk);
            q_exp.push_back(model(rd, int'(ra), rdir, rrot, rar));
            #1;
        end
        bus.in_valid = 1'b0;
        g = 0;
        while (q_exp.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        check("b2b_drain", q_exp.size(), 0);
        check("final_idle", bus.in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_data_unshifter
`default_nettype wire
